// File: rtl/vram_fill_pkg.sv
//-----------------------------------------------------------------------------
// Module      : vram_fill_pkg
// Description : Shared video constants (framebuffer geometry) and fill FSM states.
// Revision    : 1.0
//-----------------------------------------------------------------------------
`default_nettype none

package vram_fill_pkg;

  localparam int VRAM_BASE = 'h400;
  localparam int ROW_BYTES = 32;
  localparam int ROWS      = 224;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_e;

endpackage

`default_nettype wire

// File: rtl/vram_cursor.sv
//-----------------------------------------------------------------------------
// Module      : vram_cursor
// Description : Row/column counters and framebuffer address register for the fill walk.
// Revision    : 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module vram_cursor #(
  parameter int RAM_ADDR_WIDTH = 13,
  parameter int VRAM_BASE      = 'h400,
  parameter int ROW_BYTES      = 32,
  parameter int ROWS           = 224,
  parameter int ROW_W          = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int COL_W          = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      step,
  output logic                      last,
  output logic [ROW_W-1:0]          row,
  output logic [COL_W-1:0]          col,
  output logic [RAM_ADDR_WIDTH-1:0] addr
);

  logic [ROW_W-1:0]          row_q, row_d;
  logic [COL_W-1:0]          col_q, col_d;
  logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                      col_end;

  assign col_end = (col_q == COL_W'(ROW_BYTES - 1));
  assign last    = col_end && (row_q == ROW_W'(ROWS - 1));

  // Stepping at the last byte holds position so the address never leaves the framebuffer.
  always_comb begin
    row_d  = row_q;
    col_d  = col_q;
    addr_d = addr_q;
    if (clear) begin
      row_d  = '0;
      col_d  = '0;
      addr_d = RAM_ADDR_WIDTH'(VRAM_BASE);
    end else if (step && !last) begin
      addr_d = addr_q + RAM_ADDR_WIDTH'(1);
      if (col_end) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q  <= '0;
      col_q  <= '0;
      addr_q <= RAM_ADDR_WIDTH'(VRAM_BASE);
    end else begin
      row_q  <= row_d;
      col_q  <= col_d;
      addr_q <= addr_d;
    end
  end

  assign row  = row_q;
  assign col  = col_q;
  assign addr = addr_q;

endmodule

`default_nettype wire

// File: rtl/vram_fill.sv
//-----------------------------------------------------------------------------
// Module      : vram_fill
// Description : Framebuffer fill engine stealing RAM cycles via bus_req/bus_gnt.
//               Define VRAM_FILL_PATTERN_EN for the 8x8 checkerboard test pattern.
// Revision    : 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module vram_fill #(
  parameter int RAM_SIZE       = 8192,
  parameter int RAM_ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int XLEN           = 8,
  parameter int VRAM_BASE      = vram_fill_pkg::VRAM_BASE,
  parameter int ROW_BYTES      = vram_fill_pkg::ROW_BYTES,
  parameter int ROWS           = vram_fill_pkg::ROWS
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [XLEN-1:0]           fill_data,
  output logic                      busy,
  output logic                      done,
  output logic                      bus_req,
  input  logic                      bus_gnt,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
  output logic [XLEN-1:0]           ram_wdata,
  output logic                      ram_we
);

  import vram_fill_pkg::*;

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1;

  fill_state_e               state_q, state_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [XLEN-1:0]           fill_q, fill_d;
  logic                      cur_clear, cur_step, cur_last;
  logic [ROW_W-1:0]          cur_row;
  logic [COL_W-1:0]          cur_col;
  logic [RAM_ADDR_WIDTH-1:0] cur_addr;
  logic [XLEN-1:0]           pix_data;
  logic                      unused_cursor;

  vram_cursor #(
    .RAM_ADDR_WIDTH(RAM_ADDR_WIDTH),
    .VRAM_BASE     (VRAM_BASE),
    .ROW_BYTES     (ROW_BYTES),
    .ROWS          (ROWS),
    .ROW_W         (ROW_W),
    .COL_W         (COL_W)
  ) u_cursor (
    .clk  (clk),
    .rst  (rst),
    .clear(cur_clear),
    .step (cur_step),
    .last (cur_last),
    .row  (cur_row),
    .col  (cur_col),
    .addr (cur_addr)
  );

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    cur_clear = 1'b0;
    cur_step  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FILL;
          fill_d    = fill_data;
          cur_clear = 1'b1;
        end
      end
      FILL: begin
        if (bus_gnt) begin
          cur_step = 1'b1;
          if (cur_last) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == FILL);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      fill_q  <= fill_d;
    end
  end

`ifdef VRAM_FILL_PATTERN_EN
  // Invert every other byte and every 8th row band: 8x8-pixel checkerboard.
  assign pix_data = fill_q ^ {XLEN{cur_row[3] ^ cur_col[0]}};
`else
  assign pix_data = fill_q;
`endif

  assign unused_cursor = ^{cur_row, cur_col};

  assign busy      = busy_q;
  assign bus_req   = busy_q;
  assign done      = done_q;
  assign ram_we    = busy_q & bus_gnt;
  assign ram_addr  = cur_addr;
  assign ram_wdata = busy_q ? pix_data : '0;

endmodule

`default_nettype wire

// File: tb/tb_vram_fill.sv
//-----------------------------------------------------------------------------
// Module      : tb_vram_fill
// Description : Self-checking bench for vram_fill against a byte-count model.
// Revision    : 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module tb_vram_fill;

  localparam int BASE  = 'h400;
  localparam int TOTAL = 224 * 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        bus_gnt = 1'b0;
  logic [7:0]  fill_data = 8'h00;
  logic        busy, done, bus_req, ram_we;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wdata;

  vram_fill dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .fill_data(fill_data),
    .busy     (busy),
    .done     (done),
    .bus_req  (bus_req),
    .bus_gnt  (bus_gnt),
    .ram_addr (ram_addr),
    .ram_wdata(ram_wdata),
    .ram_we   (ram_we)
  );

  always #5 clk = ~clk;

  // Model state: 0 idle, 1 filling (k bytes written so far), 2 done pulse.
  int          mode = 0;
  int          k = 0;
  logic [7:0]  mf = 8'h00;
  bit          addr_known = 1'b1;
  bit          model_valid = 1'b0;
  int          edge_n = 0;
  int          start_edge = 0;

  always @(posedge clk) begin
    edge_n      <= edge_n + 1;
    model_valid <= 1'b1;
    if (rst) begin
      mode       <= 0;
      k          <= 0;
      addr_known <= 1'b1;
    end else begin
      case (mode)
        0: if (start) begin
             mode       <= 1;
             k          <= 0;
             mf         <= fill_data;
             start_edge <= edge_n + 1;
             addr_known <= 1'b0;
           end
        1: if (bus_gnt) begin
             if (k == TOTAL - 1) mode <= 2;
             else                k <= k + 1;
           end
        default: mode <= 0;
      endcase
    end
  end

  function automatic logic [7:0] exp_byte(input logic [7:0] f, input int idx);
`ifdef VRAM_FILL_PATTERN_EN
    // checker flips every 8 rows and on every odd byte
    return ((((idx / 32) / 8) + idx) % 2 == 1) ? ~f : f;
`else
    return f;
`endif
  endfunction

  int         n_pass = 0;
  int         n_total = 0;
  int         done_cnt = 0;
  int         wr_cnt = 0;
  int         last_lat = 0;
  int         phase = 0;
  int         gnt_mode = 0;
  logic [7:0] ram [8192];
  int         wphase [8192];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic compare();
    chk("busy",    32'(busy),    32'(mode == 1));
    chk("bus_req", 32'(bus_req), 32'(mode == 1));
    chk("done",    32'(done),    32'(mode == 2));
    chk("ram_we",  32'(ram_we),  32'((mode == 1) && bus_gnt));
    if (mode == 1)      chk("ram_addr", 32'(ram_addr), 32'(BASE + k));
    else if (addr_known) chk("ram_addr_reset", 32'(ram_addr), 32'(BASE));
    if (mode != 1)      chk("ram_wdata_idle", 32'(ram_wdata), 32'h0);
    else if (bus_gnt)   chk("ram_wdata", 32'(ram_wdata), 32'(exp_byte(mf, k)));
    if (ram_we === 1'b1) begin
      ram[ram_addr]    = ram_wdata;
      wphase[ram_addr] = phase;
      wr_cnt++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      last_lat = edge_n - start_edge;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (model_valid) compare();
    @(posedge clk);
    #1;
    case (gnt_mode)
      0:       bus_gnt = 1'b1;
      1:       bus_gnt = ~bus_gnt;
      default: bus_gnt = ($urandom_range(3) != 0);
    endcase
  endtask

  task automatic start_fill(input logic [7:0] fd);
    start     = 1'b1;
    fill_data = fd;
    tick();
    start     = 1'b0;
    fill_data = 8'($urandom);
  endtask

  // restart_at >= 0: re-assert start with fill 00 once that many writes happened
  task automatic wait_done(input int budget, input int restart_at);
    int d0 = done_cnt;
    int w0 = wr_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      if (restart_at >= 0 && (wr_cnt - w0) >= restart_at && (wr_cnt - w0) < restart_at + 5) begin
        start     = 1'b1;
        fill_data = 8'h00;
      end else begin
        start     = 1'b0;
        fill_data = 8'($urandom);
      end
      tick();
      n++;
    end
    start = 1'b0;
    chk("done_within_budget", 32'(done_cnt != d0), 32'h1);
  endtask

  task automatic check_region(input string name, input int ph, input logic [7:0] f);
    int bad = 0;
    for (int a = BASE; a < BASE + TOTAL; a++) begin
      if (wphase[13'(a)] != ph || ram[13'(a)] !== exp_byte(f, a - BASE)) bad++;
    end
    chk(name, 32'(bad), 32'h0);
    chk("no_write_below_base", 32'(wphase[13'h3FF]), 32'h0);
  endtask

  initial begin
    int d0, w0, n;
    for (int a = 0; a < 8192; a++) begin
      ram[a]    = 8'h5C;
      wphase[a] = 0;
    end

    // reset
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_busy",      32'(busy),      32'h0);
    chk("reset_done",      32'(done),      32'h0);
    chk("reset_bus_req",   32'(bus_req),   32'h0);
    chk("reset_ram_we",    32'(ram_we),    32'h0);
    chk("reset_ram_addr",  32'(ram_addr),  32'h400);
    chk("reset_ram_wdata", 32'(ram_wdata), 32'h0);
    tick();

    // phase 1: constant grant, A5
    phase = 1; gnt_mode = 0; bus_gnt = 1'b1;
    w0 = wr_cnt; d0 = done_cnt;
    start_fill(8'hA5);
    wait_done(8000, -1);
    chk("full_grant_latency", 32'(last_lat), 32'd7168);
    chk("full_grant_writes",  32'(wr_cnt - w0), 32'd7168);
    repeat (3) tick();
    chk("full_grant_one_done", 32'(done_cnt - d0), 32'h1);
    check_region("fill_all_a5", 1, 8'hA5);

    // phase 2: toggling grant
    phase = 2; gnt_mode = 1;
    start_fill(8'h3C);
    wait_done(16000, -1);
    chk("toggle_latency", 32'(last_lat == 14335 || last_lat == 14336), 32'h1);
    repeat (3) tick();
    check_region("toggle_fill", 2, 8'h3C);

    // phase 3: random grant, start with 00 re-asserted mid-fill
    phase = 3; gnt_mode = 2; d0 = done_cnt;
    start_fill(8'hA5);
    wait_done(20000, 3000);
    repeat (4) tick();
    chk("restart_ignored_one_done", 32'(done_cnt - d0), 32'h1);
    check_region("restart_still_a5", 3, 8'hA5);

    // phase 4: reset after 100 writes
    phase = 4; d0 = done_cnt; w0 = wr_cnt; n = 0;
    start_fill(8'hA5);
    while ((wr_cnt - w0) < 100 && n < 1000) begin tick(); n++; end
    chk("reached_100_writes", 32'(wr_cnt - w0 >= 100), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy",     32'(busy),     32'h0);
    chk("abort_bus_req",  32'(bus_req),  32'h0);
    chk("abort_ram_we",   32'(ram_we),   32'h0);
    chk("abort_ram_addr", 32'(ram_addr), 32'h400);
    repeat (4) tick();
    chk("abort_no_done", 32'(done_cnt - d0), 32'h0);

    // phase 5: fresh fill after abort, FF (pattern visible when enabled)
    phase = 5;
    start_fill(8'hFF);
    wait_done(20000, -1);
    repeat (2) tick();
    check_region("fresh_fill", 5, 8'hFF);
`ifdef VRAM_FILL_PATTERN_EN
    chk("pat_400", 32'(ram[13'h400]), 32'hFF);
    chk("pat_401", 32'(ram[13'h401]), 32'h00);
    chk("pat_500", 32'(ram[13'h500]), 32'h00);
    chk("pat_501", 32'(ram[13'h501]), 32'hFF);
`else
    chk("pat_400", 32'(ram[13'h400]), 32'hFF);
    chk("pat_401", 32'(ram[13'h401]), 32'hFF);
    chk("pat_500", 32'(ram[13'h500]), 32'hFF);
    chk("pat_501", 32'(ram[13'h501]), 32'hFF);
`endif

    // phase 6: start held through DONE -> back-to-back fills
    phase = 6; gnt_mode = 0; d0 = done_cnt; n = 0;
    start = 1'b1; fill_data = 8'hA5;
    while (done_cnt == d0 && n < 8000) begin tick(); n++; end
    chk("b2b_first_done", 32'(done_cnt - d0), 32'h1);
    tick();
    start = 1'b0;
    chk("b2b_refill_busy", 32'(busy), 32'h1);
    wait_done(8000, -1);
    repeat (4) tick();
    chk("b2b_done_pulses", 32'(done_cnt - d0), 32'h2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
